// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and sizing helpers for the I2C command arbiter
// Contents: arbiter state enum, controller word width, counter width helpers.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    RELEASE
  } arb_state_e;

  // {slave address, sub-address, data}
  localparam int I2C_WORD_W = 24;

  // Extra RELEASE cycles before the next grant, so that the gap between
  // a done/err pulse and the next ctl_go is at least four cycles.
  localparam int RELEASE_HOLD = 2;

  // Bits needed to hold values 0..max_val (at least 1).
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // The timer counts 0..TIMEOUT_CYC-1 and also holds RELEASE_HOLD.
  function automatic int timer_w(input int timeout_cyc);
    return width_for((timeout_cyc > RELEASE_HOLD) ? timeout_cyc : RELEASE_HOLD);
  endfunction

endpackage

// File: rtl/i2c_arb_sync2.sv
// rtl/i2c_arb_sync2.sv - two-flop synchroniser with configurable reset value
// Ports: iCLK/iRST_N clock and async active-low reset, d asynchronous input,
//        q synchronised output (RST_VAL while in reset).
module i2c_arb_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one I2C controller among N_REQ requesters
// Ports: iCLK/iRST_N clock and async active-low reset; req/req_data requester
//        levels and 24-bit words; done/err per-requester result pulses; busy
//        grant-to-result flag; ctl_go/ctl_data controller command; ctl_end/ctl_ack
//        controller status from the I2C clock domain.
// Build option: I2C_ARB_RETRY_EN enables NACK re-issue up to MAX_RETRY times.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic [N_REQ-1:0]            req,
  input  logic [I2C_WORD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]            done,
  output logic [N_REQ-1:0]            err,
  output logic                        busy,
  output logic                        ctl_go,
  output logic [I2C_WORD_W-1:0]       ctl_data,
  input  logic                        ctl_end,
  input  logic                        ctl_ack
);

  localparam int IDX_W   = width_for(N_REQ - 1);
  localparam int TMR_W   = timer_w(TIMEOUT_CYC);
  localparam int RETRY_W = width_for(MAX_RETRY);

`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  arb_state_e             state_q, state_n;
  logic [IDX_W-1:0]       rr_q, rr_n, gnt_q, gnt_n;
  logic [TMR_W-1:0]       tmr_q, tmr_n;
  logic [RETRY_W-1:0]     retry_q, retry_n;
  logic                   go_n, busy_n;
  logic [I2C_WORD_W-1:0]  data_n;
  logic [N_REQ-1:0]       done_n, err_n;
  logic                   end_s, ack_s, tmo;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx, cand;
  logic [I2C_WORD_W-1:0]  req_word [N_REQ];

  // END idles high on the controller, so its synchroniser resets to 1.
  i2c_arb_sync2 #(.RST_VAL(1'b1)) u_sync_end (
    .iCLK(iCLK), .iRST_N(iRST_N), .d(ctl_end), .q(end_s)
  );
  i2c_arb_sync2 #(.RST_VAL(1'b0)) u_sync_ack (
    .iCLK(iCLK), .iRST_N(iRST_N), .d(ctl_ack), .q(ack_s)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_word
    assign req_word[i] = req_data[i*I2C_WORD_W +: I2C_WORD_W];
  end

  // Scan from the far end towards rr so the nearest set bit at/after rr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign tmo = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n = state_q;
    rr_n    = rr_q;
    gnt_n   = gnt_q;
    tmr_n   = tmr_q;
    retry_n = retry_q;
    data_n  = ctl_data;
    busy_n  = busy;
    done_n  = '0;
    err_n   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_n   = pick_idx;
          data_n  = req_word[pick_idx];
          busy_n  = 1'b1;
          tmr_n   = '0;
          retry_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        tmr_n = tmr_q + 1'b1;
        // A completion seen in WAIT takes precedence over a same-cycle timeout.
        if (state_q == WAIT && end_s) begin
          state_n = CHECK;
        end else if (tmo) begin
          err_n[gnt_q] = 1'b1;
          busy_n       = 1'b0;
          tmr_n        = '0;
          state_n      = RELEASE;
        end else if (state_q == ISSUE && !end_s) begin
          state_n = WAIT;
        end
      end
      CHECK: begin
        tmr_n = '0;
        if (!ack_s) begin
          done_n[gnt_q] = 1'b1;
          busy_n        = 1'b0;
          state_n       = RELEASE;
        end else if (RETRY_EN && (retry_q < RETRY_W'(MAX_RETRY))) begin
          retry_n = retry_q + 1'b1;
          state_n = ISSUE;
        end else begin
          err_n[gnt_q] = 1'b1;
          busy_n       = 1'b0;
          state_n      = RELEASE;
        end
      end
      RELEASE: begin
        rr_n = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        // ctl_go is already low here; wait for the controller to show END
        // idle again, and hold off long enough to space out back-to-back grants.
        if (tmr_q < TMR_W'(RELEASE_HOLD)) begin
          tmr_n = tmr_q + 1'b1;
        end else if (end_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    go_n = (state_n == ISSUE) || (state_n == WAIT);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      tmr_q    <= '0;
      retry_q  <= '0;
      ctl_go   <= 1'b0;
      ctl_data <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_n;
      rr_q     <= rr_n;
      gnt_q    <= gnt_n;
      tmr_q    <= tmr_n;
      retry_q  <= retry_n;
      ctl_go   <= go_n;
      ctl_data <= data_n;
      done     <= done_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;

  localparam int N    = 3;
  localparam int TOUT = 100;
  localparam int MAXR = 3;
  localparam int R_ACK = 0, R_NACK = 1, R_STALL = 2;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [23:0]   words [N];
  logic [71:0]   req_data;
  logic [N-1:0]  done, err;
  logic          busy, ctl_go;
  logic [23:0]   ctl_data;
  logic          ctl_end = 1'b1;
  logic          ctl_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int resp_q[$];
  int exp_q[$];
  int grant_log[$];
  int gos_log[$];
  int err_log[$];
  int run_log[$];

  assign req_data = {words[2], words[1], words[0]};

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TOUT), .MAX_RETRY(MAXR)) dut (
    .iCLK(clk), .iRST_N(rst_n), .req(req), .req_data(req_data),
    .done(done), .err(err), .busy(busy), .ctl_go(ctl_go), .ctl_data(ctl_data),
    .ctl_end(ctl_end), .ctl_ack(ctl_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Controller model: per GO, accept (END low), then finish with ACK/NACK,
  // or stall with END low until GO is withdrawn.
  int cs = 0, cnt = 0, cur = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cs = 0; cnt = 0; ctl_end = 1'b1; ctl_ack = 1'b0;
    end else begin
      case (cs)
        0: if (ctl_go) begin
             cur = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
             cs = 1; cnt = 0;
           end
        1: begin
             cnt++;
             if (cnt == 3) begin
               ctl_end = 1'b0; cnt = 0;
               cs = (cur == R_STALL) ? 4 : 2;
             end
           end
        2: begin
             cnt++;
             if (cnt == 4) ctl_ack = (cur == R_NACK);
             if (cnt == 5) begin ctl_end = 1'b1; cs = 3; end
           end
        3: if (!ctl_go) cs = 0;
        4: if (!ctl_go) begin cs = 5; cnt = 0; end
        5: begin
             cnt++;
             if (cnt == 3) begin ctl_end = 1'b1; cs = 0; end
           end
        default: cs = 0;
      endcase
    end
  end

  // Transaction-level reference model and per-cycle compare.
  int rr_m = 0, g_m = 0, gos = 0, exp_gos = 0;
  int since_end = 100, since_fall = 100, go_run = 0, last_run = 0;
  bit in_txn = 0, exp_err = 0, exp_stall = 0;
  logic go_prev = 1'b0;
  logic [N-1:0] req_prev = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 0; rr_m = 0; go_prev = 1'b0; since_end = 100; since_fall = 100;
      go_run = 0; req_prev = req;
    end else begin
      since_end++;
      since_fall++;
      if (ctl_go) go_run++;
      if (go_prev && !ctl_go) begin
        last_run = go_run; go_run = 0; since_fall = 0;
      end
      if (ctl_go && !go_prev) begin
        if (!in_txn) begin
          int g;
          g = pick(req_prev, rr_m);
          chk("grant_has_request", 32'(g >= 0), 1);
          chk("grant_gap_ge4", 32'(since_end >= 4), 1);
          g_m = (g < 0) ? 0 : g;
          in_txn = 1; gos = 0; exp_gos = 0; exp_err = 0; exp_stall = 0;
          grant_log.push_back(g_m);
          for (int k = 0; k < 16; k++) begin
            int r;
            r = (exp_q.size() > 0) ? exp_q.pop_front() : R_ACK;
            exp_gos++;
            if (r == R_ACK) break;
            if (r == R_STALL) begin exp_err = 1; exp_stall = 1; break; end
            if (!RETRY || exp_gos > MAXR) begin exp_err = 1; break; end
          end
        end
        gos++;
      end
      if (ctl_go && in_txn) chk("ctl_data_word", 32'(ctl_data), 32'(words[g_m]));
      if ((done | err) != 0) begin
        if (!in_txn) begin
          chk("pulse_outside_txn", 32'({done, err}), 0);
        end else begin
          chk("pulse_target", 32'(done | err), 32'(1 << g_m));
          chk("pulse_exclusive", 32'(done & err), 0);
          chk("pulse_is_err", 32'(err != 0), 32'(exp_err));
          chk("go_count", gos, exp_gos);
          chk("pulse_latency", since_fall, exp_stall ? 0 : 1);
          if (exp_stall) chk("timeout_go_cycles", last_run, TOUT);
          gos_log.push_back(gos);
          err_log.push_back(int'(err != 0));
          run_log.push_back(last_run);
          in_txn = 0; rr_m = (g_m + 1) % N; since_end = 0;
        end
      end
      chk("busy", 32'(busy), 32'(in_txn));
      go_prev = ctl_go;
      req_prev = req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (done[i] | err[i]) req[i] = 1'b0;
  endtask

  task automatic push_resp(input int r);
    resp_q.push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((req != 0 || busy) && n < budget) begin tick(); n++; end
    chk({name, "_idle"}, 32'({busy, req}), 0);
    repeat (10) tick();
  endtask

  initial begin
    int base, n;
    words[0] = 24'h34001A;
    words[1] = 24'h40120F;
    words[2] = 24'h56ABCD;
    repeat (3) tick();
    chk("rst_ctl_go", 32'(ctl_go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_ctl_data", 32'(ctl_data), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single request
    push_resp(R_ACK);
    req = 3'b001;
    wait_idle("single", 300);
    chk("single_count", grant_log.size(), 1);
    chk("single_grant", grant_log[0], 0);
    chk("single_gos", gos_log[0], 1);
    chk("single_is_err", err_log[0], 0);
    chk("single_data_hold", 32'(ctl_data), 32'h34001A);

    // Contention from rr=0 with requester 0 re-requesting during 1's service
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1; tick();
    base = grant_log.size();
    repeat (4) push_resp(R_ACK);
    req = 3'b111;
    n = 0;
    while (!(ctl_go && ctl_data == words[1]) && n < 300) begin tick(); n++; end
    chk("contention_saw_grant1", 32'(ctl_go && ctl_data == words[1]), 1);
    req[0] = 1'b1;
    wait_idle("contention", 600);
    chk("contention_count", grant_log.size() - base, 4);
    chk("contention_order0", grant_log[base], 0);
    chk("contention_order1", grant_log[base+1], 1);
    chk("contention_order2", grant_log[base+2], 2);
    chk("contention_order3", grant_log[base+3], 0);

    // NACK handling (rr=1 here)
    base = grant_log.size();
    if (RETRY) begin
      push_resp(R_NACK); push_resp(R_NACK); push_resp(R_ACK);
      req = 3'b010;
      wait_idle("retry_ok", 600);
      repeat (4) push_resp(R_NACK);
      req = 3'b010;
      wait_idle("retry_fail", 800);
      chk("nack_count", grant_log.size() - base, 2);
      chk("retry_ok_gos", gos_log[base], 3);
      chk("retry_ok_is_err", err_log[base], 0);
      chk("retry_fail_gos", gos_log[base+1], 4);
      chk("retry_fail_is_err", err_log[base+1], 1);
    end else begin
      push_resp(R_NACK); push_resp(R_ACK);
      req = 3'b011;
      wait_idle("nack", 600);
      chk("nack_count", grant_log.size() - base, 2);
      chk("nack_grant", grant_log[base], 1);
      chk("nack_gos", gos_log[base], 1);
      chk("nack_is_err", err_log[base], 1);
      chk("nack_next_grant", grant_log[base+1], 0);
      chk("nack_next_is_err", err_log[base+1], 0);
    end

    // Timeout on requester 2, then requester 0 is served
    base = grant_log.size();
    push_resp(R_STALL); push_resp(R_ACK);
    req = 3'b101;
    wait_idle("timeout", 1000);
    chk("timeout_count", grant_log.size() - base, 2);
    chk("timeout_grant", grant_log[base], 2);
    chk("timeout_is_err", err_log[base], 1);
    chk("timeout_run", run_log[base], 100);
    chk("timeout_next_grant", grant_log[base+1], 0);
    chk("timeout_next_is_err", err_log[base+1], 0);

    // Reset during WAIT; pending requests re-granted from rr=0
    push_resp(R_ACK);
    req = 3'b010;
    wait_idle("pre_reset", 300);
    push_resp(R_STALL);
    req = 3'b101;
    n = 0;
    while (ctl_end && n < 100) begin tick(); n++; end
    chk("reset_saw_accept", 32'(ctl_end), 0);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl_go", 32'(ctl_go), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done_err", 32'({done, err}), 0);
    resp_q.delete();
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    base = grant_log.size();
    push_resp(R_ACK); push_resp(R_ACK);
    wait_idle("post_reset", 600);
    chk("post_reset_count", grant_log.size() - base, 2);
    chk("post_reset_first", grant_log[base], 0);
    chk("post_reset_second", grant_log[base+1], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares the single I2C controller between several configuration requesters, e.g. audio codec setup, video decoder setup and runtime volume writes. Each requester presents one 24-bit write {slave address, sub-address, data}. The block grants requesters round-robin, drives the controller's GO/DATA handshake and synchronises END/ACK back from the slow I2C clock domain. It reports per-requester completion or error, with a timeout and optional NACK retry.

## Interface
- N_REQ, 3: number of requesters (2..4)
- TIMEOUT_CYC, 2000000: iCLK cycles allowed from GO to END before abort (40 ms at 50 MHz)
- MAX_RETRY, 3: NACK re-issues before error (used only with retry feature)
- iCLK  in  1  system clock, 50 MHz
- iRST_N  in  1  reset, asynchronous, active-low; clock iCLK
- req  in  N_REQ  per-requester request level; held until that requester's done or err pulse
- req_data  in  24*N_REQ  requester i's word at bits [24*i+23:24*i], as {slave, sub, data}
- done  out  N_REQ  one-cycle pulse: transfer acknowledged
- err  out  N_REQ  one-cycle pulse: NACK after retries exhausted, or timeout
- busy  out  1  high from grant until done/err
- ctl_go  out  1  GO to controller
- ctl_data  out  24  DATA to controller, stable while ctl_go high
- ctl_end  in  1  controller END (I2C clock domain, asynchronous to iCLK)
- ctl_ack  in  1  controller ACK; 0 = all bytes acked, 1 = NACK

## Operation
- ctl_end and ctl_ack each pass through a 2-flop synchroniser; all decisions use synchronised values.
- Reset values: state IDLE, ctl_go 0, ctl_data 0, done/err 0, busy 0, rr pointer 0, retry count 0, timer 0.
- IDLE: if any req bit is set, grant the first set bit at or after rr pointer, wrapping. Latch req_data slice into ctl_data. Assert busy. Go to ISSUE.
- ISSUE: ctl_go=1. Wait for synchronised END=0 (controller accepted). Then go to WAIT.
- WAIT: hold ctl_go=1. On synchronised END=1, go to CHECK.
- CHECK: ctl_go=0.
  - ACK=0: pulse done[g]. Go to RELEASE.
  - ACK=1: handled per Configuration.
- RELEASE: deassert busy. Set rr pointer to g+1 mod N_REQ. Return to IDLE only once synchronised END is seen at 1 with ctl_go low for one cycle.
- Timeout: the timer counts in ISSUE and WAIT. At TIMEOUT_CYC it forces ctl_go=0, pulses err[g] and goes to RELEASE.
- Requester deasserting req mid-transfer: the transfer completes; the done/err pulse is still issued.
- A new req from the current grantee is not seen until the next IDLE. rr fairness guarantees another pending requester goes first.

## Timing
- Grant: ctl_go rises 1 cycle after the IDLE cycle that samples req.
- ctl_data changes only in the IDLE→ISSUE transition.
- Synchroniser adds 2 iCLK cycles to END/ACK observation.
- done/err asserts exactly one cycle, in the CHECK (or timeout) cycle plus 1.
- Back-to-back requests: at least 4 iCLK cycles between done and the next ctl_go.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously). No done/err is produced.

## Configuration
- I2C_ARB_RETRY_EN defined:
  - NACK with retry count < MAX_RETRY: increment the count, clear the timer, return to ISSUE (ctl_go re-asserted the next cycle, same ctl_data).
  - NACK at MAX_RETRY: pulse err.
  - Retry count clears on grant.
- Undefined: any NACK pulses err immediately. MAX_RETRY is ignored.

## Structure
- Package i2c_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, CHECK, RELEASE}
  - I2C_WORD_W=24
  - timer width derived from TIMEOUT_CYC
- Sub-module i2c_arb_sync2: 2-flop synchroniser with reset value 1 for END and 0 for ACK (reset value as parameter).

## Test plan
- Single request: req=001, data 0x34001A, controller model acks → ctl_data=0x34001A, one ctl_go, done=001 for one cycle, busy low afterwards.
- Contention: req=111 from rr=0 → service order 0,1,2. Re-assert req0 during service of 1 → order continues 2 then 0.
- NACK with I2C_ARB_RETRY_EN, MAX_RETRY=3: model NACKs 2× then acks → 3 GO assertions, done only. With 4 NACKs → 4 GOs, err pulse.
- NACK without macro: one NACK → single GO, err pulse, next requester granted.
- Timeout: END never returns, TIMEOUT_CYC=100 → ctl_go drops and err asserts at cycle 100+sync latency. The arbiter then serves the next request.
- Reset asserted during WAIT → ctl_go, busy, done, err all 0 in the same cycle. After release, a pending req is re-granted from rr=0.
